// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter that shares the regfile's single write port between ALU writeback and multdiv.
// Optional starvation guard for buffered multdiv results: define STARVE_GUARD_EN.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        md_valid,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        alu_stall,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [3:0]  fifo_count
);

  localparam int PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Unsupported sizes leave this marker scope in the elaborated hierarchy.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      STARVE_LIMIT < 1) begin : gIllegalConfig
  end

  logic [4:0]      fifoReg  [FIFO_DEPTH];
  logic [31:0]     fifoData [FIFO_DEPTH];
  logic [PtrW-1:0] rdPtr;
  logic [PtrW-1:0] wrPtr;
  logic [3:0]      count;

  logic fifoEmpty;
  logic fifoFull;
  logic mdAccept;
  logic mdLive;
  logic aluEff;
  logic forceHead;
  logic grantAlu;
  logic grantHead;
  logic grantBypass;
  logic push;
  logic pop;

  assign fifoEmpty = (count == 4'd0);
  assign fifoFull  = (count >= 4'(FIFO_DEPTH));

  // Ready looks only at registered occupancy, so a same-cycle pop never opens a slot.
  assign md_ready  = ~ctrl_reset & ~fifoFull;
  assign mdAccept  = md_valid & md_ready;
  assign mdLive    = mdAccept & (md_reg != 5'd0);
  assign aluEff    = alu_valid & (alu_reg != 5'd0);

`ifdef STARVE_GUARD_EN
  localparam int CntW = $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] starveCnt;

  assign forceHead = ~fifoEmpty & (starveCnt == CntW'(STARVE_LIMIT));

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      starveCnt <= '0;
    end else if (fifoEmpty || grantHead) begin
      starveCnt <= '0;
    end else if (starveCnt != CntW'(STARVE_LIMIT)) begin
      starveCnt <= starveCnt + CntW'(1);
    end
  end
`else
  assign forceHead = 1'b0;
`endif

  always_comb begin
    grantAlu    = 1'b0;
    grantHead   = 1'b0;
    grantBypass = 1'b0;
    alu_stall   = 1'b0;
    if (ctrl_reset) begin
      grantAlu = 1'b0;
    end else if (forceHead) begin
      grantHead = 1'b1;
      alu_stall = aluEff;
    end else if (aluEff) begin
      grantAlu = 1'b1;
    end else if (!fifoEmpty) begin
      grantHead = 1'b1;
    end else if (mdLive) begin
      grantBypass = 1'b1;
    end
  end

  always_comb begin
    ctrl_writeEnable = grantAlu | grantHead | grantBypass;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'd0;
    if (grantAlu) begin
      ctrl_writeReg = alu_reg;
      data_writeReg = alu_data;
    end else if (grantHead) begin
      ctrl_writeReg = fifoReg[rdPtr];
      data_writeReg = fifoData[rdPtr];
    end else if (grantBypass) begin
      ctrl_writeReg = md_reg;
      data_writeReg = md_data;
    end
  end

  assign push = mdLive & ~grantBypass;
  assign pop  = grantHead;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= 4'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoReg[i]  <= 5'd0;
        fifoData[i] <= 32'd0;
      end
    end else begin
      if (push) begin
        fifoReg[wrPtr]  <= md_reg;
        fifoData[wrPtr] <= md_data;
        wrPtr           <= wrPtr + PtrW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: per-cycle status checks plus a write scoreboard.
// Expectations for the starvation scenario follow STARVE_GUARD_EN.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        ctrl_reset;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        alu_stall;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [3:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] mdd;
    logic [6:0]  st;
    logic        ew;
    logic [4:0]  er;
    logic [31:0] ed;
  } step_t;

  wr_t         expQ[$];
  wr_t         popped;
  logic [31:0] shadowRf [32];
  wire  [6:0]  status = {ctrl_writeEnable, alu_stall, md_ready, fifo_count};

  regfile_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .alu_valid(alu_valid),
    .alu_reg(alu_reg),
    .alu_data(alu_data),
    .md_valid(md_valid),
    .md_reg(md_reg),
    .md_data(md_data),
    .md_ready(md_ready),
    .alu_stall(alu_stall),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .fifo_count(fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: every regfile write must match the oldest outstanding expected write.
  always @(negedge clock) begin
    if (!ctrl_reset && ctrl_writeEnable) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write got r%0d=%h required no write", ctrl_writeReg, data_writeReg);
      end else begin
        popped = expQ.pop_front();
        if ({ctrl_writeReg, data_writeReg} !== {popped.r, popped.d}) begin
          errors++;
          $display("[TB] FAIL write_order got r%0d=%h required r%0d=%h",
                   ctrl_writeReg, data_writeReg, popped.r, popped.d);
        end
      end
      shadowRf[ctrl_writeReg] = data_writeReg;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] stat(input logic we, input logic stall, input logic rdy, input int cnt);
    return {we, stall, rdy, 4'(cnt)};
  endfunction

  function automatic step_t mk(input logic av, input logic [4:0] ar, input logic mv, input logic [4:0] mr,
                               input logic [31:0] mdd, input logic [6:0] st,
                               input logic ew, input logic [4:0] er, input logic [31:0] ed);
    step_t s;
    s.av = av;  s.ar = ar;  s.ad = 32'hA000 + 32'(ar);
    s.mv = mv;  s.mr = mr;  s.mdd = mdd;
    s.st = st;  s.ew = ew;  s.er = er;  s.ed = ed;
    return s;
  endfunction

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] mdd);
    alu_valid = av;  alu_reg = ar;  alu_data = ad;
    md_valid  = mv;  md_reg  = mr;  md_data  = mdd;
  endtask

  task automatic pushExp(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    expQ.push_back(e);
  endtask

  // Power-on reset, then a mid-cycle reset while the FIFO is full and the ALU requests r5.
  task automatic test_reset();
    ctrl_reset = 1'b1;
    drive(1, 5'd5, 32'h5555, 1, 5'd6, 32'h6666);
    #2;
    checks++;
    if ({status, ctrl_writeReg, data_writeReg} !== 44'd0) begin
      errors++;
      $display("[TB] FAIL reset_por got %b/%0d/%h required all zero", status, ctrl_writeReg, data_writeReg);
    end
    nextCycle();
    ctrl_reset = 1'b0;
    drive(1, 5'd1, 32'hA001, 1, 5'd4, 32'hD004);
    pushExp(5'd1, 32'hA001);
    #2;
    checks++;
    if (status !== stat(1, 0, 1, 0)) begin
      errors++;
      $display("[TB] FAIL reset_fill0 status got %b required %b", status, stat(1, 0, 1, 0));
    end
    nextCycle();
    drive(1, 5'd2, 32'hA002, 1, 5'd5, 32'hD005);
    pushExp(5'd2, 32'hA002);
    #2;
    checks++;
    if (status !== stat(1, 0, 1, 1)) begin
      errors++;
      $display("[TB] FAIL reset_fill1 status got %b required %b", status, stat(1, 0, 1, 1));
    end
    nextCycle();
    drive(1, 5'd5, 32'hA005, 1, 5'd6, 32'hD006);
    #2;
    checks++;
    if (status !== stat(1, 0, 0, 2)) begin
      errors++;
      $display("[TB] FAIL reset_full status got %b required %b", status, stat(1, 0, 0, 2));
    end
    ctrl_reset = 1'b1;
    #1;
    checks++;
    if ({status, ctrl_writeReg, data_writeReg} !== 44'd0) begin
      errors++;
      $display("[TB] FAIL reset_async got %b/%0d/%h required all zero", status, ctrl_writeReg, data_writeReg);
    end
    nextCycle();
    #2;
    checks++;
    if ({status, ctrl_writeReg, data_writeReg} !== 44'd0) begin
      errors++;
      $display("[TB] FAIL reset_held got %b/%0d/%h required all zero", status, ctrl_writeReg, data_writeReg);
    end
    nextCycle();
    ctrl_reset = 1'b0;
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    #2;
    checks++;
    if (status !== stat(0, 0, 1, 0)) begin
      errors++;
      $display("[TB] FAIL reset_release status got %b required %b", status, stat(0, 0, 1, 0));
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_drain pending got %0d required 0", expQ.size());
    end
  endtask

  // ALU wins a collision; multdiv result is buffered and retires on the next idle-ALU edge.
  task automatic test_alu_priority();
    step_t s[$];
    s.push_back(mk(1, 5'd3, 1, 5'd7, 32'hBEEF, stat(1, 0, 1, 0), 1, 5'd3, 32'hA003));
    s.push_back(mk(0, 5'd0, 0, 5'd0, 32'h0,    stat(1, 0, 1, 1), 1, 5'd7, 32'hBEEF));
    s.push_back(mk(0, 5'd0, 0, 5'd0, 32'h0,    stat(0, 0, 1, 0), 0, 5'd0, 32'h0));
    s[0].ad = 32'h1234;
    s[0].ed = 32'h1234;
    for (int i = 0; i < s.size(); i++) begin
      nextCycle();
      drive(s[i].av, s[i].ar, s[i].ad, s[i].mv, s[i].mr, s[i].mdd);
      if (s[i].ew) pushExp(s[i].er, s[i].ed);
      #2;
      checks++;
      if (status !== s[i].st) begin
        errors++;
        $display("[TB] FAIL alu_priority[%0d] status got %b required %b", i, status, s[i].st);
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL alu_priority_drain pending got %0d required 0", expQ.size());
    end
  endtask

  // Empty FIFO and idle ALU: multdiv result goes straight to the port.
  task automatic test_bypass();
    step_t s[$];
    s.push_back(mk(0, 5'd0, 1, 5'd9, 32'hCAFE, stat(1, 0, 1, 0), 1, 5'd9, 32'hCAFE));
    s.push_back(mk(0, 5'd0, 0, 5'd0, 32'h0,    stat(0, 0, 1, 0), 0, 5'd0, 32'h0));
    for (int i = 0; i < s.size(); i++) begin
      nextCycle();
      drive(s[i].av, s[i].ar, s[i].ad, s[i].mv, s[i].mr, s[i].mdd);
      if (s[i].ew) pushExp(s[i].er, s[i].ed);
      #2;
      checks++;
      if (status !== s[i].st) begin
        errors++;
        $display("[TB] FAIL bypass[%0d] status got %b required %b", i, status, s[i].st);
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL bypass_drain pending got %0d required 0", expQ.size());
    end
  endtask

  // Writes to r0 from either source are discarded; an r0 ALU request lets the FIFO head through.
  task automatic test_zero_reg();
    step_t s[$];
    s.push_back(mk(1, 5'd0, 0, 5'd0, 32'h0,    stat(0, 0, 1, 0), 0, 5'd0, 32'h0));
    s.push_back(mk(1, 5'd2, 1, 5'd0, 32'h99,   stat(1, 0, 1, 0), 1, 5'd2, 32'hA002));
    s.push_back(mk(0, 5'd0, 0, 5'd0, 32'h0,    stat(0, 0, 1, 0), 0, 5'd0, 32'h0));
    s.push_back(mk(0, 5'd0, 1, 5'd0, 32'h77,   stat(0, 0, 1, 0), 0, 5'd0, 32'h0));
    s.push_back(mk(1, 5'd1, 1, 5'd4, 32'hD004, stat(1, 0, 1, 0), 1, 5'd1, 32'hA001));
    s.push_back(mk(1, 5'd0, 0, 5'd0, 32'h0,    stat(1, 0, 1, 1), 1, 5'd4, 32'hD004));
    s.push_back(mk(0, 5'd0, 0, 5'd0, 32'h0,    stat(0, 0, 1, 0), 0, 5'd0, 32'h0));
    s[5].ad = 32'hDEAD;
    for (int i = 0; i < s.size(); i++) begin
      nextCycle();
      drive(s[i].av, s[i].ar, s[i].ad, s[i].mv, s[i].mr, s[i].mdd);
      if (s[i].ew) pushExp(s[i].er, s[i].ed);
      #2;
      checks++;
      if (status !== s[i].st) begin
        errors++;
        $display("[TB] FAIL zero_reg[%0d] status got %b required %b", i, status, s[i].st);
      end
    end
    checks++;
    if (expQ.size() != 0 || shadowRf[0] !== 32'd0) begin
      errors++;
      $display("[TB] FAIL zero_reg_drain pending got %0d r0=%h required 0 and 0", expQ.size(), shadowRf[0]);
    end
  endtask

  // Continuous ALU stream with three multdiv results against a two-entry FIFO.
  task automatic test_starvation();
    step_t s[$];
    s.push_back(mk(1, 5'd11, 1, 5'd20, 32'hD020, stat(1, 0, 1, 0), 1, 5'd11, 32'hA00B));
    s.push_back(mk(1, 5'd12, 1, 5'd21, 32'hD021, stat(1, 0, 1, 1), 1, 5'd12, 32'hA00C));
`ifdef STARVE_GUARD_EN
    s.push_back(mk(1, 5'd13, 1, 5'd22, 32'hD022, stat(1, 0, 0, 2), 1, 5'd13, 32'hA00D));
    s.push_back(mk(1, 5'd14, 1, 5'd22, 32'hD022, stat(1, 0, 0, 2), 1, 5'd14, 32'hA00E));
    s.push_back(mk(1, 5'd15, 1, 5'd22, 32'hD022, stat(1, 0, 0, 2), 1, 5'd15, 32'hA00F));
    s.push_back(mk(1, 5'd16, 1, 5'd22, 32'hD022, stat(1, 1, 0, 2), 1, 5'd20, 32'hD020));
    s.push_back(mk(1, 5'd16, 1, 5'd22, 32'hD022, stat(1, 0, 1, 1), 1, 5'd16, 32'hA010));
    s.push_back(mk(0, 5'd0,  0, 5'd0,  32'h0,    stat(1, 0, 0, 2), 1, 5'd21, 32'hD021));
    s.push_back(mk(0, 5'd0,  0, 5'd0,  32'h0,    stat(1, 0, 1, 1), 1, 5'd22, 32'hD022));
`else
    for (int r = 13; r <= 18; r++) begin
      s.push_back(mk(1, 5'(r), 1, 5'd22, 32'hD022, stat(1, 0, 0, 2), 1, 5'(r), 32'hA000 + 32'(r)));
    end
    s.push_back(mk(0, 5'd0, 1, 5'd22, 32'hD022, stat(1, 0, 0, 2), 1, 5'd20, 32'hD020));
    s.push_back(mk(0, 5'd0, 1, 5'd22, 32'hD022, stat(1, 0, 1, 1), 1, 5'd21, 32'hD021));
    s.push_back(mk(0, 5'd0, 0, 5'd0,  32'h0,    stat(1, 0, 1, 1), 1, 5'd22, 32'hD022));
`endif
    s.push_back(mk(0, 5'd0, 0, 5'd0, 32'h0, stat(0, 0, 1, 0), 0, 5'd0, 32'h0));
    for (int i = 0; i < s.size(); i++) begin
      nextCycle();
      drive(s[i].av, s[i].ar, s[i].ad, s[i].mv, s[i].mr, s[i].mdd);
      if (s[i].ew) pushExp(s[i].er, s[i].ed);
      #2;
      checks++;
      if (status !== s[i].st) begin
        errors++;
        $display("[TB] FAIL starvation[%0d] status got %b required %b", i, status, s[i].st);
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL starvation_drain pending got %0d required 0", expQ.size());
    end
  endtask

  // Two results for the same register must retire in acceptance order.
  task automatic test_back_to_back();
    step_t s[$];
    s.push_back(mk(1, 5'd1, 1, 5'd10, 32'h1, stat(1, 0, 1, 0), 1, 5'd1,  32'hA001));
    s.push_back(mk(1, 5'd2, 1, 5'd10, 32'h2, stat(1, 0, 1, 1), 1, 5'd2,  32'hA002));
    s.push_back(mk(0, 5'd0, 0, 5'd0,  32'h0, stat(1, 0, 0, 2), 1, 5'd10, 32'h1));
    s.push_back(mk(0, 5'd0, 0, 5'd0,  32'h0, stat(1, 0, 1, 1), 1, 5'd10, 32'h2));
    s.push_back(mk(0, 5'd0, 0, 5'd0,  32'h0, stat(0, 0, 1, 0), 0, 5'd0,  32'h0));
    for (int i = 0; i < s.size(); i++) begin
      nextCycle();
      drive(s[i].av, s[i].ar, s[i].ad, s[i].mv, s[i].mr, s[i].mdd);
      if (s[i].ew) pushExp(s[i].er, s[i].ed);
      #2;
      checks++;
      if (status !== s[i].st) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d] status got %b required %b", i, status, s[i].st);
      end
    end
    checks++;
    if (shadowRf[10] !== 32'h2 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL back_to_back_r10 got %h pending %0d required 00000002 pending 0",
               shadowRf[10], expQ.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadowRf[i] = 32'd0;
    test_reset();
    test_alu_priority();
    test_bypass();
    test_zero_reg();
    test_starvation();
    test_back_to_back();
    nextCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
